// File: rtl/clock_divider_bank.sv
// clock_divider_bank
//   NUM_CH independent clock dividers running from one system clock. Each channel
//   counts 0..D and, at terminal count, toggles its clk_out and raises tick for one
//   cycle. The divisor D is written through a shared valid/ready port. On an enabled
//   channel the new divisor is held as pending and only applied at the next terminal
//   count, so a half-period is never cut short. On a disabled channel it is applied
//   immediately.
//
// Ports
//   clk        system clock, all state on posedge
//   reset      synchronous reset, active-low
//   en         per-channel run enable
//   cfg_valid  divisor write request
//   cfg_ready  write accepted when cfg_valid && cfg_ready (combinational)
//   cfg_ch     target channel; out-of-range channels accept and discard the write
//   cfg_div    new divisor D
//   clk_out    divided square wave, period 2*(D+1)
//   tick       one-cycle strobe at each terminal count
//   pending    channel holds an accepted divisor that is not yet applied
module clock_divider_bank #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 4999,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0]  cnt_q      [NUM_CH];
    logic [CNT_W-1:0]  cnt_d      [NUM_CH];
    logic [CNT_W-1:0]  div_act_q  [NUM_CH];
    logic [CNT_W-1:0]  div_act_d  [NUM_CH];
    logic [CNT_W-1:0]  div_pend_q [NUM_CH];
    logic [CNT_W-1:0]  div_pend_d [NUM_CH];
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] term;

    // Ready only drops for an in-range channel that already holds a pending divisor.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i) && pending_q[i]) begin
                cfg_ready = 1'b0;
            end
        end
    end

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        clk_out_d  = clk_out_q;
        tick_d     = '0;
        pending_d  = pending_q;
        term       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            term[i] = (cnt_q[i] == div_act_q[i]);
            if (en[i]) begin
                if (term[i]) begin
                    cnt_d[i]     = '0;
                    clk_out_d[i] = ~clk_out_q[i];
                    tick_d[i]    = 1'b1;
                    if (pending_q[i]) begin
                        div_act_d[i] = div_pend_q[i];
                        pending_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
                // A write can only land when nothing is pending, so it never
                // collides with the apply above; it waits for the next terminal count.
                if (wr_sel[i]) begin
                    div_pend_d[i] = cfg_div;
                    pending_d[i]  = 1'b1;
                end
            end else if (wr_sel[i]) begin
                // Idle channel: no half-period in flight, apply straight away.
                div_act_d[i] = cfg_div;
                cnt_d[i]     = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]      <= '0;
                div_act_q[i]  <= DefDiv;
                div_pend_q[i] <= '0;
            end
            clk_out_q <= '0;
            tick_q    <= '0;
            pending_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            pending_q  <= pending_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
module tb_clock_divider_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [3:0] clk_out, tick, pending;

    // Five-channel instance: channel index 5 is representable but out of range.
    logic [4:0] en5;
    logic       cfg_valid5;
    logic       cfg_ready5;
    logic [2:0] cfg_ch5;
    logic [7:0] cfg_div5;
    logic [4:0] clk_out5, tick5, pending5;

    int tests = 0;
    int fails = 0;

    clock_divider_bank #(
        .NUM_CH      (4),
        .CNT_W       (8),
        .DEFAULT_DIV (4)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    clock_divider_bank #(
        .NUM_CH      (5),
        .CNT_W       (8),
        .DEFAULT_DIV (4)
    ) u_dut5 (
        .clk       (clk),
        .reset     (reset),
        .en        (en5),
        .cfg_valid (cfg_valid5),
        .cfg_ready (cfg_ready5),
        .cfg_ch    (cfg_ch5),
        .cfg_div   (cfg_div5),
        .clk_out   (clk_out5),
        .tick      (tick5),
        .pending   (pending5)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b0;
        en         = 4'h0;
        cfg_valid  = 1'b0;
        cfg_ch     = 2'd0;
        cfg_div    = 8'd0;
        en5        = 5'h00;
        cfg_valid5 = 1'b0;
        cfg_ch5    = 3'd0;
        cfg_div5   = 8'd0;

        step(2);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_clk_out", 32'(clk_out), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h1);

        // Release: edges counted from here.
        reset = 1'b1;
        en    = 4'hF;
        en5   = 5'h1F;
        step(4);                                         // e4
        check("e4_no_tick", 32'(tick), 32'h0);
        step(1);                                         // e5
        check("e5_first_tick", 32'(tick), 32'hF);
        check("e5_clk_out", 32'(clk_out), 32'hF);
        check("e5_tick5", 32'(tick5), 32'h1F);
        step(1);                                         // e6, cnt=1
        check("e6_tick_low", 32'(tick), 32'h0);

        cfg_valid  = 1'b1;
        cfg_ch     = 2'd1;
        cfg_div    = 8'd2;
        cfg_valid5 = 1'b1;
        cfg_ch5    = 3'd5;
        cfg_div5   = 8'd0;
        check("wr1_ready", 32'(cfg_ready), 32'h1);
        check("oob_ready", 32'(cfg_ready5), 32'h1);
        step(1);                                         // e7, D=2 accepted
        cfg_div    = 8'd7;                               // second write held
        cfg_valid5 = 1'b0;
        check("e7_pending", 32'(pending), 32'h2);
        check("e7_ready_blocked", 32'(cfg_ready), 32'h0);
        check("oob_pending5", 32'(pending5), 32'h0);

        step(3);                                         // e10, old period ends
        check("e10_tick", 32'(tick), 32'hF);
        check("e10_clk_out", 32'(clk_out), 32'h0);
        check("e10_pending", 32'(pending), 32'h0);
        check("e10_ready", 32'(cfg_ready), 32'h1);
        check("oob_tick5", 32'(tick5), 32'h1F);
        step(1);                                         // e11, D=7 accepted
        cfg_valid = 1'b0;
        check("e11_pending", 32'(pending), 32'h2);
        step(2);                                         // e13, D=2 period tick
        check("e13_tick", 32'(tick), 32'h2);
        check("e13_clk_out", 32'(clk_out), 32'h2);
        check("e13_pending", 32'(pending), 32'h0);
        check("oob_tick5_idle", 32'(tick5), 32'h0);
        step(2);                                         // e15
        check("e15_tick", 32'(tick), 32'hD);
        check("e15_clk_out", 32'(clk_out), 32'hF);
        check("oob_tick5_e15", 32'(tick5), 32'h1F);
        step(5);                                         // e20
        check("e20_tick", 32'(tick), 32'hD);
        check("e20_clk_out", 32'(clk_out), 32'h2);
        step(1);                                         // e21, ch1 D=7 tick
        check("e21_tick", 32'(tick), 32'h2);
        check("e21_clk_out", 32'(clk_out), 32'h0);

        en = 4'b1011;                                    // freeze ch2 at cnt=1
        step(1);                                         // e22
        check("e22_tick", 32'(tick), 32'h0);
        step(1);                                         // e23
        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_div   = 8'd0;
        check("dis_ready", 32'(cfg_ready), 32'h1);
        step(1);                                         // e24, applied at once
        cfg_valid = 1'b0;
        check("e24_pending", 32'(pending), 32'h0);
        step(1);                                         // e25
        check("e25_tick", 32'(tick), 32'h9);
        check("e25_clk_out", 32'(clk_out), 32'h9);
        step(3);                                         // e28
        check("e28_tick", 32'(tick), 32'h0);
        check("e28_clk_out", 32'(clk_out), 32'h9);
        en = 4'hF;
        step(1);                                         // e29
        check("e29_tick", 32'(tick), 32'h6);
        check("e29_clk_out", 32'(clk_out), 32'hF);
        step(1);                                         // e30
        check("e30_tick", 32'(tick), 32'hD);
        check("e30_clk_out", 32'(clk_out), 32'h2);
        step(1);                                         // e31
        check("e31_tick", 32'(tick), 32'h4);
        check("e31_clk_out", 32'(clk_out), 32'h6);

        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 8'd9;
        step(1);                                         // e32
        check("e32_pending", 32'(pending), 32'h1);
        // Reset edge coinciding with another handshake: reset must win.
        cfg_ch  = 2'd3;
        cfg_div = 8'd1;
        reset   = 1'b0;
        step(1);
        check("rst2_tick", 32'(tick), 32'h0);
        check("rst2_clk_out", 32'(clk_out), 32'h0);
        check("rst2_pending", 32'(pending), 32'h0);
        check("rst2_clk_out5", 32'(clk_out5), 32'h0);
        reset     = 1'b1;
        cfg_valid = 1'b0;
        step(4);
        check("rst2_e4", 32'(tick), 32'h0);
        step(1);
        check("rst2_e5_tick", 32'(tick), 32'hF);
        check("rst2_e5_clk_out", 32'(clk_out), 32'hF);
        step(1);
        check("rst2_e6_tick", 32'(tick), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
